// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and defaults for the ROM read arbiter: FSM state encoding and width helpers.
package rom_arb_pkg;

  localparam int DEF_NREQ     = 2;
  localparam int DEF_AW       = 6;
  localparam int DEF_DW       = 9;
  localparam int DEF_ROM_LAT  = 2;
  localparam int DEF_INIT_CYC = 4;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  // Width of an index into n items, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side bus of the ROM read arbiter: requests, addresses, grants and read responses.
//
// Handshake: a requester raises Req[i] with Addr slice i and holds both until Gnt[i] is seen;
// the request is consumed on the rising edge where Gnt[i]=1. Responses have no backpressure:
// RspData belongs to requester i in exactly the cycle RspValid[i]=1.
interface rom_read_arbiter_if #(
  parameter int NREQ = rom_arb_pkg::DEF_NREQ,
  parameter int AW   = rom_arb_pkg::DEF_AW,
  parameter int DW   = rom_arb_pkg::DEF_DW
) ();

  logic [NREQ-1:0]    Req;
  logic [NREQ*AW-1:0] Addr;
  logic [NREQ-1:0]    Gnt;
  logic [NREQ-1:0]    RspValid;
  logic [DW-1:0]      RspData;

  modport master (
    output Req,
    output Addr,
    input  Gnt,
    input  RspValid,
    input  RspData
  );

  modport slave (
    input  Req,
    input  Addr,
    output Gnt,
    output RspValid,
    output RspData
  );

endinterface

// File: rtl/rom_read_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or above ptr_i, wrapping to 0.
module rr_pick
  import rom_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  id_o,
  output logic            any_o
);

  always_comb begin
    int idx;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (int'(ptr_i) + off) % NREQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one registered-output ROM among NREQ requesters with round-robin grants, one read
// per cycle, and owns ROM init hold, clock-enable gating and pipeline drain.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int ROM_LAT  = DEF_ROM_LAT,
  parameter int INIT_CYC = DEF_INIT_CYC
) (
  input  logic                OutClock,
  input  logic                Reset,
  input  logic                Enable,
  rom_read_arbiter_if.slave   bus,
  output logic [AW-1:0]       RomAddress,
  output logic                RomClockEn,
  output logic                RomReset,
  input  logic [DW-1:0]       RomQ,
  output logic                Busy,
  output arb_state_e          DbgState
);

  localparam int IDW  = id_width(NREQ);
  localparam int CW   = id_width(INIT_CYC);
  localparam int LAST = ROM_LAT - 1;

  arb_state_e         state_q, state_d;
  logic [CW-1:0]      init_cnt_q, init_cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [AW-1:0]      rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]     tag_id_q [ROM_LAT];
  logic [IDW-1:0]     tag_id_d [ROM_LAT];

  logic [NREQ-1:0]    pick_gnt;
  logic [IDW-1:0]     pick_id;
  logic               pick_any;
  logic               grant;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req_i (bus.Req),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .id_o  (pick_id),
    .any_o (pick_any)
  );

  // Enable is used combinationally so a falling Enable blocks the grant in the same cycle.
  assign grant   = (state_q == ST_RUN) && Enable && pick_any;
  assign bus.Gnt = grant ? pick_gnt : '0;

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CW'(INIT_CYC - 1)) state_d = ST_IDLE;
        else                                 init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_IDLE:  if (Enable)            state_d = ST_RUN;
      ST_RUN:   if (!Enable)           state_d = ST_DRAIN;
      ST_DRAIN: if (tag_vld_q == '0)   state_d = ST_IDLE;
      default:                         state_d = ST_INIT;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    if (grant) begin
      ptr_d      = (pick_id == IDW'(NREQ - 1)) ? '0 : pick_id + 1'b1;
      rom_addr_d = bus.Addr[int'(pick_id)*AW +: AW];
    end
  end

  // Tag pipe mirrors the ROM's address and output registers, so its last stage lines up with RomQ.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '{default: '0};
    tag_vld_d[0] = grant;
    tag_id_d[0]  = pick_id;
    for (int i = 1; i < ROM_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
  end

  always_ff @(posedge OutClock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      ptr_q      <= '0;
      rom_addr_q <= '0;
      tag_vld_q  <= '0;
      tag_id_q   <= '{default: '0};
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      tag_vld_q  <= tag_vld_d;
      tag_id_q   <= tag_id_d;
    end
  end

  always_comb begin
    bus.RspValid = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.RspValid[i] = tag_vld_q[LAST] && (tag_id_q[LAST] == IDW'(i));
    end
  end

  assign bus.RspData = tag_vld_q[LAST] ? RomQ : '0;
  assign RomAddress  = rom_addr_q;
  assign RomClockEn  = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign RomReset    = (state_q == ST_INIT);
  assign Busy        = ((state_q != ST_RUN) && (state_q != ST_IDLE)) || (|tag_vld_q);
  assign DbgState    = state_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter: a 2-requester instance for most scenarios and a
// 3-requester instance for pointer wrap, each backed by a registered-output ROM model.
module tb_rom_read_arbiter;
  import rom_arb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [5:0] rom_addr2, rom_addr3;
  logic       rce2, rce3, rrst2, rrst3, busy2, busy3;
  logic [8:0] romq2, romq3;
  arb_state_e st2, st3;

  int n_cmp;
  int n_err;

  rom_read_arbiter_if #(.NREQ(2), .AW(6), .DW(9)) i2 ();
  rom_read_arbiter_if #(.NREQ(3), .AW(6), .DW(9)) i3 ();

  rom_read_arbiter #(.NREQ(2), .AW(6), .DW(9), .ROM_LAT(2), .INIT_CYC(4)) u_dut2 (
    .OutClock   (clk),
    .Reset      (rst_n),
    .Enable     (enable),
    .bus        (i2),
    .RomAddress (rom_addr2),
    .RomClockEn (rce2),
    .RomReset   (rrst2),
    .RomQ       (romq2),
    .Busy       (busy2),
    .DbgState   (st2)
  );

  rom_read_arbiter #(.NREQ(3), .AW(6), .DW(9), .ROM_LAT(2), .INIT_CYC(4)) u_dut3 (
    .OutClock   (clk),
    .Reset      (rst_n),
    .Enable     (enable),
    .bus        (i3),
    .RomAddress (rom_addr3),
    .RomClockEn (rce3),
    .RomReset   (rrst3),
    .RomQ       (romq3),
    .Busy       (busy3),
    .DbgState   (st3)
  );

  // ROM contents: word(a) = 7*a + 3, e.g. 3->24, 5->38, 7->52, 10->73, 60->423.
  function automatic logic [8:0] rom_word(input logic [5:0] a);
    return 9'(int'(a) * 7 + 3);
  endfunction

  always @(posedge clk) begin
    if (rrst2)     romq2 <= '0;
    else if (rce2) romq2 <= rom_word(rom_addr2);
    if (rrst3)     romq3 <= '0;
    else if (rce3) romq3 <= rom_word(rom_addr3);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n  = 1'b1;
    enable = 1'b1;
    i2.Req = '0; i2.Addr = '0;
    i3.Req = '0; i3.Addr = '0;
    #2 rst_n = 1'b0;
    i2.Req  = 2'b01;
    i2.Addr = {6'd0, 6'd5};
    @(negedge clk); #1;
    n_cmp++; if (i2.Gnt !== 2'b00) begin n_err++; $display("FAIL rst_gnt: got %b want 00", i2.Gnt); end
    n_cmp++; if (i2.RspValid !== 2'b00) begin n_err++; $display("FAIL rst_rspvalid: got %b want 00", i2.RspValid); end
    n_cmp++; if (i2.RspData !== 9'd0) begin n_err++; $display("FAIL rst_rspdata: got %0d want 0", i2.RspData); end
    n_cmp++; if (rom_addr2 !== 6'd0) begin n_err++; $display("FAIL rst_romaddr: got %0d want 0", rom_addr2); end
    n_cmp++; if (rce2 !== 1'b0) begin n_err++; $display("FAIL rst_clken: got %b want 0", rce2); end
    n_cmp++; if (rrst2 !== 1'b1) begin n_err++; $display("FAIL rst_romreset: got %b want 1", rrst2); end
    n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL rst_busy: got %b want 1", busy2); end
    n_cmp++; if (st2 !== ST_INIT) begin n_err++; $display("FAIL rst_state: got %0d want %0d", st2, ST_INIT); end
    @(negedge clk); rst_n = 1'b1; #1;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (rrst2 !== 1'b1 || st2 !== ST_INIT) begin n_err++; $display("FAIL init_hold[%0d]: romreset %b state %0d want 1/%0d", c, rrst2, st2, ST_INIT); end
      n_cmp++; if (i2.Gnt !== 2'b00) begin n_err++; $display("FAIL init_gnt[%0d]: got %b want 00", c, i2.Gnt); end
    end
    @(negedge clk); #1;
    n_cmp++; if (st2 !== ST_IDLE) begin n_err++; $display("FAIL idle_state: got %0d want %0d", st2, ST_IDLE); end
    n_cmp++; if (rrst2 !== 1'b0 || rce2 !== 1'b0) begin n_err++; $display("FAIL idle_rom: romreset %b clken %b want 0/0", rrst2, rce2); end
    n_cmp++; if (i2.Gnt !== 2'b00) begin n_err++; $display("FAIL idle_gnt: got %b want 00", i2.Gnt); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy2); end
    i2.Req = 2'b00;
    @(negedge clk); #1;
    n_cmp++; if (st2 !== ST_RUN || rce2 !== 1'b1) begin n_err++; $display("FAIL run_entry: state %0d clken %b want %0d/1", st2, rce2, ST_RUN); end
    n_cmp++; if (st3 !== ST_RUN) begin n_err++; $display("FAIL run_entry3: got %0d want %0d", st3, ST_RUN); end
  endtask

  task automatic test_single();
    @(negedge clk);
    i2.Req  = 2'b01;
    i2.Addr = {6'd0, 6'd5};
    #1;
    n_cmp++; if (i2.Gnt !== 2'b01) begin n_err++; $display("FAIL single_gnt: got %b want 01", i2.Gnt); end
    @(negedge clk); i2.Req = 2'b00; #1;
    n_cmp++; if (i2.Gnt !== 2'b00) begin n_err++; $display("FAIL single_gnt_drop: got %b want 00", i2.Gnt); end
    n_cmp++; if (i2.RspValid !== 2'b00) begin n_err++; $display("FAIL single_early_rsp: got %b want 00", i2.RspValid); end
    n_cmp++; if (rom_addr2 !== 6'd5) begin n_err++; $display("FAIL single_romaddr: got %0d want 5", rom_addr2); end
    n_cmp++; if (busy2 !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy2); end
    @(negedge clk); #1;
    n_cmp++; if (i2.RspValid !== 2'b01) begin n_err++; $display("FAIL single_rspvalid: got %b want 01", i2.RspValid); end
    n_cmp++; if (i2.RspData !== 9'd38) begin n_err++; $display("FAIL single_rspdata: got %0d want 38", i2.RspData); end
    @(negedge clk); #1;
    n_cmp++; if (i2.RspValid !== 2'b00 || i2.RspData !== 9'd0) begin n_err++; $display("FAIL single_rsp_end: valid %b data %0d want 00/0", i2.RspValid, i2.RspData); end
    n_cmp++; if (busy2 !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy2); end
  endtask

  // Pointer sits at 1 after the single read, so requester 1 wins first.
  task automatic test_back_to_back();
    logic [1:0] exp_gnt [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
    logic [1:0] exp_rv  [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
    logic [8:0] exp_rd  [6] = '{9'd0, 9'd0, 9'd423, 9'd24, 9'd423, 9'd24};
    i2.Addr = {6'd60, 6'd3};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i2.Req = (c < 4) ? 2'b11 : 2'b00;
      #1;
      n_cmp++; if (i2.Gnt !== exp_gnt[c]) begin n_err++; $display("FAIL b2b_gnt[%0d]: got %b want %b", c, i2.Gnt, exp_gnt[c]); end
      n_cmp++; if (i2.RspValid !== exp_rv[c]) begin n_err++; $display("FAIL b2b_rspvalid[%0d]: got %b want %b", c, i2.RspValid, exp_rv[c]); end
      n_cmp++; if (i2.RspData !== exp_rd[c]) begin n_err++; $display("FAIL b2b_rspdata[%0d]: got %0d want %0d", c, i2.RspData, exp_rd[c]); end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] req_v   [6] = '{3'b100, 3'b101, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [2:0] exp_gnt [6] = '{3'b100, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000};
    logic [2:0] exp_rv  [6] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b100, 3'b000};
    logic [8:0] exp_rd  [6] = '{9'd0, 9'd0, 9'd52, 9'd73, 9'd52, 9'd0};
    i3.Addr = {6'd7, 6'd0, 6'd10};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      i3.Req = req_v[c];
      #1;
      n_cmp++; if (i3.Gnt !== exp_gnt[c]) begin n_err++; $display("FAIL wrap_gnt[%0d]: got %b want %b", c, i3.Gnt, exp_gnt[c]); end
      n_cmp++; if (i3.RspValid !== exp_rv[c]) begin n_err++; $display("FAIL wrap_rspvalid[%0d]: got %b want %b", c, i3.RspValid, exp_rv[c]); end
      n_cmp++; if (i3.RspData !== exp_rd[c]) begin n_err++; $display("FAIL wrap_rspdata[%0d]: got %0d want %0d", c, i3.RspData, exp_rd[c]); end
    end
  endtask

  // Enable falls with requester 0 waiting and two reads in flight; Enable bounces high in DRAIN.
  task automatic test_drain();
    logic       en_v    [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0] req_v   [6] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [1:0] exp_gnt [6] = '{2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
    logic [1:0] exp_rv  [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [8:0] exp_rd  [6] = '{9'd0, 9'd0, 9'd24, 9'd423, 9'd0, 9'd0};
    arb_state_e exp_st  [6] = '{ST_RUN, ST_RUN, ST_RUN, ST_DRAIN, ST_DRAIN, ST_IDLE};
    logic       exp_bsy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    i2.Addr = {6'd60, 6'd3};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      enable = en_v[c];
      i2.Req = req_v[c];
      #1;
      n_cmp++; if (i2.Gnt !== exp_gnt[c]) begin n_err++; $display("FAIL drain_gnt[%0d]: got %b want %b", c, i2.Gnt, exp_gnt[c]); end
      n_cmp++; if (i2.RspValid !== exp_rv[c] || i2.RspData !== exp_rd[c]) begin n_err++; $display("FAIL drain_rsp[%0d]: valid %b data %0d want %b/%0d", c, i2.RspValid, i2.RspData, exp_rv[c], exp_rd[c]); end
      n_cmp++; if (st2 !== exp_st[c]) begin n_err++; $display("FAIL drain_state[%0d]: got %0d want %0d", c, st2, exp_st[c]); end
      n_cmp++; if (busy2 !== exp_bsy[c]) begin n_err++; $display("FAIL drain_busy[%0d]: got %b want %b", c, busy2, exp_bsy[c]); end
    end
    n_cmp++; if (rce2 !== 1'b0) begin n_err++; $display("FAIL drain_clken_idle: got %b want 0", rce2); end
    i2.Req = 2'b00;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [1:0] rv_seen;
    arb_state_e st_at4;
    rv_seen = 2'b00;
    st_at4  = ST_RUN;
    @(negedge clk); #1;
    n_cmp++; if (st2 !== ST_RUN) begin n_err++; $display("FAIL mid_run: got %0d want %0d", st2, ST_RUN); end
    @(negedge clk);
    i2.Req  = 2'b01;
    i2.Addr = {6'd0, 6'd5};
    #1;
    n_cmp++; if (i2.Gnt !== 2'b01) begin n_err++; $display("FAIL mid_gnt: got %b want 01", i2.Gnt); end
    @(negedge clk);
    i2.Req = 2'b00;
    rst_n  = 1'b0;
    #1;
    n_cmp++; if (i2.RspValid !== 2'b00) begin n_err++; $display("FAIL mid_rsp_in_reset: got %b want 00", i2.RspValid); end
    n_cmp++; if (st2 !== ST_INIT || rrst2 !== 1'b1) begin n_err++; $display("FAIL mid_reinit: state %0d romreset %b want %0d/1", st2, rrst2, ST_INIT); end
    n_cmp++; if (busy2 !== 1'b1 || rom_addr2 !== 6'd0) begin n_err++; $display("FAIL mid_reset_outs: busy %b romaddr %0d want 1/0", busy2, rom_addr2); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      rv_seen = rv_seen | i2.RspValid;
      if (c == 4) st_at4 = st2;
    end
    n_cmp++; if (rv_seen !== 2'b00) begin n_err++; $display("FAIL mid_no_rsp: got %b want 00", rv_seen); end
    n_cmp++; if (st_at4 !== ST_IDLE) begin n_err++; $display("FAIL mid_idle_after_init: got %0d want %0d", st_at4, ST_IDLE); end
    n_cmp++; if (st2 !== ST_RUN) begin n_err++; $display("FAIL mid_rerun: got %0d want %0d", st2, ST_RUN); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_wrap();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
